// File: rtl/servo_pkg.sv
// Shared servo PWM definitions: decoder FSM encoding, timing defaults and
// clock-to-microsecond derivation, common to the SG90 generator and decoder.
package servo_pkg;

  typedef enum logic [1:0] {
    WAIT_RISE = 2'd0,
    MEAS_HIGH = 2'd1,
    MEAS_LOW  = 2'd2
  } state_e;

  localparam int ANGLE_MAX        = 180;
  localparam int DEF_CLK_HZ       = 100_000_000;
  localparam int DEF_MIN_PULSE_US = 500;
  localparam int DEF_MAX_PULSE_US = 2500;
  localparam int DEF_TIMEOUT_US   = 25000;

  function automatic int cyc_per_us(input int clk_hz);
    return clk_hz / 1_000_000;
  endfunction

endpackage

// File: rtl/us_tick_gen.sv
// Microsecond strobe: one-cycle tick every CYC_PER_US clocks. clr_i restarts
// the count so the first tick after a clear lands CYC_PER_US cycles later.
module us_tick_gen #(
  parameter int CYC_PER_US = 100
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  output logic tick_o
);

  localparam int CW = (CYC_PER_US > 1) ? $clog2(CYC_PER_US) : 1;
  localparam logic [CW-1:0] LAST = CW'(CYC_PER_US - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clr_i || (cnt_q == LAST)) cnt_d = '0;
  end

  assign tick_o = !clr_i && (cnt_q == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/sg90_pwm_decoder.sv
// Servo PWM receiver: measures high width in us, maps it to 0..180 degrees,
// flags out-of-range pulses and loss of signal. valid lags the input fall by 4 clocks.
module sg90_pwm_decoder
  import servo_pkg::*;
#(
  parameter int CLK_HZ       = DEF_CLK_HZ,
  parameter int MIN_PULSE_US = DEF_MIN_PULSE_US,
  parameter int MAX_PULSE_US = DEF_MAX_PULSE_US,
  parameter int TIMEOUT_US   = DEF_TIMEOUT_US
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pwm_in,
  output logic [11:0] pulse_us,
  output logic [7:0]  angle,
  output logic        valid,
  output logic        locked,
  output logic        err_range,
  output logic        err_timeout
);

  localparam int          CYC_PER_US = cyc_per_us(CLK_HZ);
  localparam logic [11:0] MIN_W      = 12'(MIN_PULSE_US);
  localparam logic [11:0] MAX_W      = 12'(MAX_PULSE_US);
  localparam logic [14:0] TO_W       = 15'(TIMEOUT_US);
  localparam logic [23:0] SPAN       = 24'(MAX_PULSE_US - MIN_PULSE_US);
  localparam logic [23:0] AMAX       = 24'(ANGLE_MAX);

  logic sync1_q, pwm_s_q, pwm_d_q, rise_q, fall_q;
  logic tick;

  // Edges are registered so results land exactly 4 clocks after the line falls.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      pwm_s_q <= 1'b0;
      pwm_d_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= pwm_in;
      pwm_s_q <= sync1_q;
      pwm_d_q <= pwm_s_q;
      rise_q  <= pwm_s_q & ~pwm_d_q;
      fall_q  <= ~pwm_s_q & pwm_d_q;
    end
  end

  us_tick_gen #(.CYC_PER_US(CYC_PER_US)) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (rise_q),
    .tick_o (tick)
  );

  state_e      state_q, state_d;
  logic [11:0] hi_q, hi_d, hi_nxt;
  logic [14:0] per_q, per_d, per_nxt;
  logic [11:0] pulse_q, pulse_d;
  logic [7:0]  angle_q, angle_d, scaled;
  logic        valid_q, valid_d, locked_q, locked_d;
  logic        err_range_q, err_range_d, err_to_q, err_to_d;
  logic        timeout;

  // The tick of the fall cycle itself is included, giving floor(cycles/CYC_PER_US).
  assign hi_nxt  = (tick && hi_q != 12'hFFF) ? hi_q + 12'd1 : hi_q;
  assign per_nxt = (tick && per_q != 15'h7FFF) ? per_q + 15'd1 : per_q;
  assign timeout = (per_nxt >= TO_W);
  assign scaled  = 8'(({12'd0, hi_nxt - MIN_W} * AMAX) / SPAN);

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= WAIT_RISE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (timeout) begin
      state_d = WAIT_RISE;
    end else begin
      unique case (state_q)
        WAIT_RISE: if (rise_q) state_d = MEAS_HIGH;
        MEAS_HIGH: if (fall_q) state_d = MEAS_LOW;
        MEAS_LOW:  if (rise_q) state_d = MEAS_HIGH;
        default:   state_d = WAIT_RISE;
      endcase
    end
  end

  always_comb begin
    hi_d        = hi_q;
    per_d       = per_nxt;
    pulse_d     = pulse_q;
    angle_d     = angle_q;
    valid_d     = 1'b0;
    locked_d    = locked_q;
    err_range_d = err_range_q;
    err_to_d    = err_to_q;
    if (timeout) begin
      err_to_d = 1'b1;
      locked_d = 1'b0;
      hi_d     = '0;
      per_d    = '0;
    end else begin
      unique case (state_q)
        WAIT_RISE: begin
          hi_d = '0;
          if (rise_q) per_d = '0;
        end
        MEAS_HIGH: begin
          hi_d = hi_nxt;
          if (fall_q) begin
            valid_d = 1'b1;
            pulse_d = hi_nxt;
            if (hi_nxt < MIN_W) begin
              angle_d     = 8'd0;
              err_range_d = 1'b1;
            end else if (hi_nxt > MAX_W) begin
              angle_d     = 8'(ANGLE_MAX);
              err_range_d = 1'b1;
            end else begin
              angle_d     = scaled;
              err_range_d = 1'b0;
              locked_d    = 1'b1;
              err_to_d    = 1'b0;
            end
          end
        end
        MEAS_LOW: begin
          if (rise_q) begin
            hi_d  = '0;
            per_d = '0;
          end
        end
        default: begin
          hi_d  = '0;
          per_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hi_q        <= '0;
      per_q       <= '0;
      pulse_q     <= '0;
      angle_q     <= '0;
      valid_q     <= 1'b0;
      locked_q    <= 1'b0;
      err_range_q <= 1'b0;
      err_to_q    <= 1'b0;
    end else begin
      hi_q        <= hi_d;
      per_q       <= per_d;
      pulse_q     <= pulse_d;
      angle_q     <= angle_d;
      valid_q     <= valid_d;
      locked_q    <= locked_d;
      err_range_q <= err_range_d;
      err_to_q    <= err_to_d;
    end
  end

  assign pulse_us    = pulse_q;
  assign angle       = angle_q;
  assign valid       = valid_q;
  assign locked      = locked_q;
  assign err_range   = err_range_q;
  assign err_timeout = err_to_q;

endmodule

// File: tb/tb_sg90_pwm_decoder.sv
// Bench for sg90_pwm_decoder at 2 MHz (2 clocks per us) with a shortened timeout
// so every scenario fits a short run; results are checked through a scoreboard queue.
module tb_sg90_pwm_decoder;

  localparam int CLK_HZ = 2_000_000;
  localparam int CYC    = 2;
  localparam int TO_US  = 4000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pwm_in = 1'b0;
  logic [11:0] pulse_us;
  logic [7:0]  angle;
  logic        valid, locked, err_range, err_timeout;

  always #5 clk = ~clk;

  sg90_pwm_decoder #(
    .CLK_HZ       (CLK_HZ),
    .MIN_PULSE_US (500),
    .MAX_PULSE_US (2500),
    .TIMEOUT_US   (TO_US)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pwm_in      (pwm_in),
    .pulse_us    (pulse_us),
    .angle       (angle),
    .valid       (valid),
    .locked      (locked),
    .err_range   (err_range),
    .err_timeout (err_timeout)
  );

  typedef struct {
    int          hi_us;
    int          lo_us;
    logic [11:0] pulse;
    logic [7:0]  ang;
    logic        err;
    logic        lock;
    logic        to;
    logic        chk;
  } vec_t;

  vec_t vecs[11];
  vec_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_pulse"},  pulse_us, 0);
    check({tag, "_angle"},  angle, 0);
    check({tag, "_valid"},  valid, 0);
    check({tag, "_locked"}, locked, 0);
    check({tag, "_erange"}, err_range, 0);
    check({tag, "_etmo"},   err_timeout, 0);
  endtask

  // Every valid strobe must match the oldest outstanding expectation.
  initial begin
    vec_t e;
    forever begin
      @(posedge clk);
      #1;
      if (valid) begin
        if (sb_q.size() == 0) begin
          check("unexpected_valid", 1, 0);
        end else begin
          e = sb_q.pop_front();
          if (e.chk) begin
            check("pulse_us",    pulse_us, e.pulse);
            check("angle",       angle, e.ang);
            check("err_range",   err_range, e.err);
            check("locked",      locked, e.lock);
            check("err_timeout", err_timeout, e.to);
          end
        end
      end
    end
  end

  task automatic drive_frame(input vec_t v);
    @(negedge clk);
    pwm_in = 1'b1;
    sb_q.push_back(v);
    repeat (v.hi_us * CYC) @(negedge clk);
    pwm_in = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("valid_early", valid, 0);
    @(posedge clk);
    #1 check("valid_latency", valid, 1);
    repeat (v.lo_us * CYC - 4) @(negedge clk);
  endtask

  initial begin
    vec_t v;
    vecs[0]  = '{1500, 100, 12'd1500, 8'd90,  1'b0, 1'b1, 1'b0, 1'b1};
    vecs[1]  = '{1500, 100, 12'd1500, 8'd90,  1'b0, 1'b1, 1'b0, 1'b1};
    vecs[2]  = '{1500, 100, 12'd1500, 8'd90,  1'b0, 1'b1, 1'b0, 1'b1};
    vecs[3]  = '{500,  100, 12'd500,  8'd0,   1'b0, 1'b1, 1'b0, 1'b1};
    vecs[4]  = '{1000, 100, 12'd1000, 8'd45,  1'b0, 1'b1, 1'b0, 1'b1};
    vecs[5]  = '{2500, 100, 12'd2500, 8'd180, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[6]  = '{2600, 100, 12'd2600, 8'd180, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[7]  = '{400,  100, 12'd400,  8'd0,   1'b1, 1'b1, 1'b0, 1'b1};
    vecs[8]  = '{1501, 100, 12'd1501, 8'd90,  1'b0, 1'b1, 1'b0, 1'b1};
    vecs[9]  = '{512,  100, 12'd512,  8'd1,   1'b0, 1'b1, 1'b0, 1'b1};
    vecs[10] = '{2499, 100, 12'd2499, 8'd179, 1'b0, 1'b1, 1'b0, 1'b1};

    repeat (3) @(posedge clk);
    #1 check_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    for (int i = 0; i < 11; i++) drive_frame(vecs[i]);

    // Signal loss: err_timeout must rise exactly TO_US after the last rise.
    @(negedge clk);
    pwm_in = 1'b1;
    v = '{1500, 0, 12'd1500, 8'd90, 1'b0, 1'b1, 1'b0, 1'b1};
    sb_q.push_back(v);
    repeat (1500 * CYC) @(negedge clk);
    pwm_in = 1'b0;
    repeat (3 + TO_US * CYC - 1500 * CYC) @(posedge clk);
    #1;
    check("tmo_before", err_timeout, 0);
    check("lock_before_tmo", locked, 1);
    @(posedge clk);
    #1;
    check("tmo_edge", err_timeout, 1);
    check("lock_at_tmo", locked, 0);
    repeat (50) @(negedge clk);
    drive_frame('{1500, 100, 12'd1500, 8'd90, 1'b0, 1'b1, 1'b0, 1'b1});

    // Reset mid-pulse; the remainder of the held-high line is a fresh short frame.
    @(negedge clk);
    pwm_in = 1'b1;
    repeat (700 * CYC) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1 check_zero("midrst");
    @(posedge clk);
    #1 check_zero("midrst2");
    @(negedge clk);
    rst_n = 1'b1;
    v = '{0, 0, 12'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    sb_q.push_back(v);
    repeat (800 * CYC) @(negedge clk);
    pwm_in = 1'b0;
    repeat (100 * CYC) @(negedge clk);
    drive_frame('{1500, 100, 12'd1500, 8'd90, 1'b0, 1'b1, 1'b0, 1'b1});

    // Line stuck high: timeout, and no strobe at any point.
    @(negedge clk);
    pwm_in = 1'b1;
    repeat ((TO_US + 300) * CYC) @(negedge clk);
    check("stuck_tmo", err_timeout, 1);
    check("stuck_lock", locked, 0);
    pwm_in = 1'b0;
    repeat (200) @(negedge clk);
    check("sb_drained", sb_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
